// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters for GPR and FPR files,
// issue gating on RAW hazards / saturation / in-flight cap. Optional stats: SCOREBOARD_STATS_EN.

module reg_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);
    logic dec_ok;
    assign dec_ok = dec && (cnt != '0);

    // issue+retire on the same entry cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (inc && !dec_ok)  cnt <= cnt + 1'b1;
        else if (!inc && dec_ok)  cnt <= cnt - 1'b1;
    end
endmodule

module reg_scoreboard #(
    parameter int NREG         = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 8,
    localparam int RW          = $clog2(NREG),
    localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [1:0]      iss_rw,
    input  logic [RW-1:0]   iss_rd,
    input  logic            s_use,
    input  logic            s_file,
    input  logic [RW-1:0]   s_reg,
    input  logic            t_use,
    input  logic            t_file,
    input  logic [RW-1:0]   t_reg,
    input  logic [1:0]      wb_rw,
    input  logic [RW-1:0]   wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy_gpr,
    output logic [NREG-1:0] busy_fpr,
    output logic [IW-1:0]   inflight,
    output logic            err_underflow,
    output logic [31:0]     stall_cycles
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0][NREG-1:0][CNT_W-1:0] cnt;
    logic alloc, wb_alloc, hazard_s, hazard_t, dest_sat, full, fire, wb_ok, wb_uf;

    // 01 and 10 allocate; 00 and 11 do not. Bit 1 then selects the file.
    assign alloc    = ^iss_rw;
    assign wb_alloc = ^wb_rw;

    assign hazard_s  = s_use && (cnt[s_file][s_reg] != '0);
    assign hazard_t  = t_use && (cnt[t_file][t_reg] != '0);
    assign dest_sat  = alloc && (cnt[iss_rw[1]][iss_rd] == CNT_MAX);
    assign full      = alloc && (inflight == IW'(MAX_INFLIGHT));
    assign iss_ready = !hazard_s && !hazard_t && !dest_sat && !full;

    assign fire  = iss_valid && iss_ready && alloc && !flush;
    assign wb_ok = wb_alloc && !flush && (cnt[wb_rw[1]][wb_rd] != '0);
    assign wb_uf = wb_alloc && !flush && (cnt[wb_rw[1]][wb_rd] == '0);

    for (genvar f = 0; f < 2; f++) begin : g_file
        for (genvar i = 0; i < NREG; i++) begin : g_reg
            reg_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (flush),
                .inc (fire && (iss_rw[1] == 1'(f)) && (iss_rd == RW'(i))),
                .dec (wb_alloc && (wb_rw[1] == 1'(f)) && (wb_rd == RW'(i))),
                .cnt (cnt[f][i])
            );
        end
    end

    for (genvar i = 0; i < NREG; i++) begin : g_busy
        assign busy_gpr[i] = |cnt[0][i];
        assign busy_fpr[i] = |cnt[1][i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                inflight <= '0;
        else if (flush)         inflight <= '0;
        else if (fire && !wb_ok) inflight <= inflight + 1'b1;
        else if (!fire && wb_ok) inflight <= inflight - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        err_underflow <= 1'b0;
        else if (wb_uf) err_underflow <= 1'b1;
    end

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (iss_valid && !iss_ready && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 1'b1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed + random bench for reg_scoreboard against an array-based reference model.
module tb_reg_scoreboard;
    logic        clk = 0, rst = 1;
    logic        iss_valid = 0, s_use = 0, s_file = 0, t_use = 0, t_file = 0, flush = 0;
    logic [1:0]  iss_rw = 0, wb_rw = 0;
    logic [4:0]  iss_rd = 0, s_reg = 0, t_reg = 0, wb_rd = 0;
    logic        iss_ready, err_underflow;
    logic [31:0] busy_gpr, busy_fpr, stall_cycles;
    logic [3:0]  inflight;

    int checks = 0, errors = 0;

    // reference model state
    int  m_cnt [2][32];
    int  m_infl;
    bit  m_err;
    longint m_stall;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rw(iss_rw), .iss_rd(iss_rd), .s_use(s_use), .s_file(s_file), .s_reg(s_reg),
        .t_use(t_use), .t_file(t_file), .t_reg(t_reg), .wb_rw(wb_rw), .wb_rd(wb_rd),
        .flush(flush), .busy_gpr(busy_gpr), .busy_fpr(busy_fpr), .inflight(inflight),
        .err_underflow(err_underflow), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int f = 0; f < 2; f++) for (int i = 0; i < 32; i++) m_cnt[f][i] = 0;
        m_infl = 0;
    endtask

    function automatic bit m_ready();
        bit al = (iss_rw == 2'b01) || (iss_rw == 2'b10);
        int df = (iss_rw == 2'b10) ? 1 : 0;
        if (s_use && m_cnt[s_file][s_reg] != 0) return 0;
        if (t_use && m_cnt[t_file][t_reg] != 0) return 0;
        if (al && m_cnt[df][iss_rd] == 3) return 0;
        if (al && m_infl == 8) return 0;
        return 1;
    endfunction

    task automatic check_state(input string tag);
        logic [31:0] bg, bf;
        for (int i = 0; i < 32; i++) begin
            bg[i] = (m_cnt[0][i] != 0);
            bf[i] = (m_cnt[1][i] != 0);
        end
        chk({tag, ".busy_gpr"}, busy_gpr, bg);
        chk({tag, ".busy_fpr"}, busy_fpr, bf);
        chk({tag, ".inflight"}, inflight, m_infl);
        chk({tag, ".err"}, err_underflow, m_err);
`ifdef SCOREBOARD_STATS_EN
        chk({tag, ".stall"}, stall_cycles, m_stall);
`else
        chk({tag, ".stall"}, stall_cycles, 0);
`endif
    endtask

    // One clock: drive, check mid-cycle, advance model across the edge.
    // exp_rdy: -1 = check against model only, else also against the given constant.
    task automatic step(input string tag, input bit v, input logic [1:0] rw, input int rd,
                        input bit su, input bit sf, input int sr,
                        input bit tu, input bit tf, input int tr,
                        input logic [1:0] wrw, input int wrd, input bit fl, input int exp_rdy);
        bit rdy, al, wal;
        int df, wf, pre;
        iss_valid = v; iss_rw = rw; iss_rd = 5'(rd);
        s_use = su; s_file = sf; s_reg = 5'(sr);
        t_use = tu; t_file = tf; t_reg = 5'(tr);
        wb_rw = wrw; wb_rd = 5'(wrd); flush = fl;
        #3;
        rdy = m_ready();
        chk({tag, ".ready"}, iss_ready, rdy);
        if (exp_rdy >= 0) chk({tag, ".ready_exp"}, iss_ready, exp_rdy[0]);
        check_state(tag);
        al  = (rw == 2'b01) || (rw == 2'b10);
        wal = (wrw == 2'b01) || (wrw == 2'b10);
        df  = (rw == 2'b10) ? 1 : 0;
        wf  = (wrw == 2'b10) ? 1 : 0;
        if (v && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
        @(posedge clk); #1;
        if (fl) model_clear();
        else begin
            pre = m_cnt[wf][wrd];
            if (v && rdy && al) begin m_cnt[df][rd]++; m_infl++; end
            if (wal) begin
                if (pre > 0) begin m_cnt[wf][wrd]--; m_infl--; end
                else m_err = 1;
            end
        end
    endtask

    task automatic iss(input string tag, input logic [1:0] rw, input int rd, input int er);
        step(tag, 1, rw, rd, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, er);
    endtask
    task automatic wb(input string tag, input logic [1:0] rw, input int rd);
        step(tag, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, rw, rd, 0, -1);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_clear(); m_err = 0; m_stall = 0;
        check_state("reset_async");
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        model_clear(); m_err = 0; m_stall = 0;
        #2;
        check_state("reset");
        @(posedge clk); #1;
        rst = 0;

        // RAW hazard on GPR r3
        iss("iss_r3", 2'b01, 3, 1);
        chk("busy_r3", busy_gpr, 32'h8);
        chk("infl_r3", inflight, 1);
        step("dep_r3", 1, 2'b00, 0, 1, 0, 3, 0, 0, 0, 2'b00, 0, 0, 0);
        step("dep_wb_r3", 1, 2'b00, 0, 1, 0, 3, 0, 0, 0, 2'b01, 3, 0, 0);
        chk("busy_clr_r3", busy_gpr, 0);
        step("dep_after", 1, 2'b00, 0, 1, 0, 3, 0, 0, 0, 2'b00, 0, 0, 1);

        // FPR f7 saturation
        for (int k = 0; k < 3; k++) iss("iss_f7", 2'b10, 7, 1);
        iss("sat_f7", 2'b10, 7, 0);
        wb("wb_f7", 2'b10, 7);
        iss("resat_f7", 2'b10, 7, 1);

        // in-flight cap: f7=3, plus 5 more
        for (int k = 10; k < 15; k++) iss("fill", 2'b01, k, 1);
        chk("infl_full", inflight, 8);
        iss("ninth", 2'b01, 15, 0);
        iss("nonalloc", 2'b00, 0, 1);
        iss("rw11", 2'b11, 0, 1);

        // simultaneous issue/writeback same reg, underflow
        wb("wb_f7a", 2'b10, 7);
        wb("wb_f7b", 2'b10, 7);
        iss("iss_r5", 2'b01, 5, 1);
        step("iss_wb_r5", 1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 1);
        chk("r5_busy", busy_gpr[5], 1);
        chk("r5_infl", inflight, 7);
        wb("uf_r9", 2'b01, 9);
        chk("uf_err", err_underflow, 1);
        chk("uf_infl", inflight, 7);
        // GPR 5 vs FPR 5 independence
        step("fpr5_dep", 1, 2'b00, 0, 1, 1, 5, 0, 0, 0, 2'b00, 0, 0, 1);

        // flush at inflight=4
        wb("wb_f7c", 2'b10, 7);
        wb("wb_r10", 2'b01, 10);
        wb("wb_r11", 2'b01, 11);
        chk("pre_flush", inflight, 4);
        step("flush", 1, 2'b01, 20, 1, 0, 12, 0, 0, 0, 2'b01, 12, 1, 0);
        chk("flush_infl", inflight, 0);
        chk("flush_busy", busy_gpr, 0);
        chk("flush_err", err_underflow, 1);

        // reset mid-stream, asynchronously
        iss("iss_r1", 2'b01, 1, 1);
        #2;
        do_reset();
        chk("rst_err", err_underflow, 0);

        // five stalled cycles
        iss("iss_r2", 2'b01, 2, 1);
        for (int k = 0; k < 5; k++)
            step("stall", 1, 2'b00, 0, 0, 0, 0, 1, 0, 2, 2'b00, 0, 0, 0);
`ifdef SCOREBOARD_STATS_EN
        chk("stall5", stall_cycles, 5);
`else
        chk("stall_tied", stall_cycles, 0);
`endif

        // random phase over a small register window to provoke hazards and saturation
        for (int n = 0; n < 400; n++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 49) == 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-stage scheduler for the GPR/FPR register-file datapath.
- Tracks outstanding writes per architectural register, one counter per register.
- Holds an instruction in decode until all of its source registers have retired their pending writes.
- Throttles total in-flight writes; sits between decode and the execute/writeback pipe.

Parameters:
- NREG, 32, registers per file (GPR and FPR each)
- CNT_W, 2, width of each per-register pending-write counter
- MAX_INFLIGHT, 8, maximum outstanding writes summed over both files

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- iss_valid  in  1  decode presents an instruction
- iss_ready  out  1  instruction may issue this cycle
- iss_rw  in  2  destination file: 00 none, 01 GPR, 10 FPR, 11 treated as none
- iss_rd  in  5  destination register
- s_use  in  1  source s is read
- s_file  in  1  0 GPR, 1 FPR
- s_reg  in  5  source s register
- t_use  in  1  source t is read
- t_file  in  1  0 GPR, 1 FPR
- t_reg  in  5  source t register
- wb_rw  in  2  writeback file, same encoding as iss_rw
- wb_rd  in  5  writeback register
- flush  in  1  discard all pending state
- busy_gpr  out  32  bit i set when GPR i count is non-zero
- busy_fpr  out  32  bit i set when FPR i count is non-zero
- inflight  out  4  total outstanding writes
- err_underflow  out  1  sticky: writeback arrived for a register with zero count
- stall_cycles  out  32  cycles with iss_valid=1 and iss_ready=0 (optional feature)

Behaviour:
- Reset (async, rst=1):
  - all counters = 0, inflight = 0, err_underflow = 0, stall_cycles = 0
  - outputs go to reset values immediately, without waiting for a clock edge
- Hazard:
  - hazard_s = s_use and count[s_file][s_reg] != 0; hazard_t likewise.
  - Hazards use only registered counts. A writeback in the same cycle does NOT clear the hazard, because the register file updates on that edge and decode reads the old value. Earliest issue is the cycle after the writeback edge.
- iss_ready:
  - iss_ready = !hazard_s and !hazard_t and !dest_sat and !(alloc and inflight == MAX_INFLIGHT)
  - alloc = iss_rw in {01,10}
  - dest_sat = alloc and count[dest] == 2^CNT_W-1
  - iss_ready is combinational and independent of iss_valid.
- Issue: when iss_valid and iss_ready and alloc, count[dest]+1 and inflight+1 at the next edge. A non-allocating issue (branches, stores, out, j, jr) changes no state.
- Writeback: wb_rw in {01,10} with count[wb] > 0 gives count[wb]-1 and inflight-1.
- Writeback to a zero count: no state change, err_underflow set to 1 and held until rst.
- Simultaneous issue and writeback, same register: count unchanged, inflight unchanged.
- Simultaneous issue and writeback, different registers: both applied; inflight unchanged.
- Files are independent: GPR 5 and FPR 5 are distinct entries.
- GPR 0 is tracked like any other register, because the register file writes it.
- flush:
  - At the next edge, all counts and inflight are cleared; the same-cycle issue and writeback are ignored.
  - err_underflow is not cleared by flush.
  - iss_ready still evaluates from pre-flush state during the flush cycle.
- Arithmetic: counters never wrap. Saturation is prevented by stall on the issue side and by underflow suppression on the writeback side.
- Latency: issue to busy bit visible, 1 cycle; writeback to busy clear, 1 cycle.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- Defined: stall_cycles increments each cycle with iss_valid=1 and iss_ready=0, saturates at 32'hFFFFFFFF, and clears on rst only (not flush).
- Undefined: stall_cycles tied to 0 and no counter is instantiated.

Test Plan:
- Reset, then issue GPR r3 (iss_rw=01, iss_rd=3) -> next cycle busy_gpr=32'h8, inflight=1; a following instruction with s_reg=3, s_use=1, s_file=0 sees iss_ready=0.
- Writeback wb_rw=01, wb_rd=3 in the same cycle as a dependent instruction -> iss_ready=0 that cycle; 1 the next cycle; busy_gpr=0.
- Issue FPR f7 three times with CNT_W=2, fourth issue to f7 -> iss_ready=0 (count=3); one writeback to f7 -> next cycle iss_ready=1.
- 8 allocating issues to distinct registers -> inflight=8; ninth allocating issue stalls; non-allocating issue (iss_rw=00, no sources) still gets iss_ready=1.
- Issue and writeback to GPR r5 (count 1) in the same cycle -> count stays 1, inflight unchanged; writeback to r9 with count 0 -> err_underflow=1, inflight unchanged.
- flush with inflight=4, then assert rst mid-stream -> after flush inflight=0 and busy=0 while err_underflow is retained; rst clears everything asynchronously; with SCOREBOARD_STATS_EN, 5 stalled cycles give stall_cycles=5.
